// File: rtl/load_store_unit.sv
// Load/store master for a word-addressed 32-bit data memory with 1-cycle registered reads.
// One request at a time: loads read+extend, sw writes directly, sb/sh read-modify-write.
module load_store_unit #(
  parameter int MEM_DEPTH = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Req,
  input  logic        IsStore,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ByteAddress,
  input  logic [31:0] StoreData,
  output logic        Ready,
  output logic        Done,
  output logic        Fault,
  output logic [31:0] LoadData,
  output logic        MemWriteEnable,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_MERGE, S_WRITE, S_DONE
  } state_t;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [31:0] addr;   // word index
    logic [31:0] wdata;  // store source, replaced by the merged word for sb/sh
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [31:0] load_data_q, load_data_d;

  logic        req_fault;
  logic [31:0] word_idx;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;
  logic [31:0] merged;

  assign word_idx = {2'b00, ByteAddress[31:2]};

  always_comb begin
    req_fault = 1'b0;
    case (Funct3)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = ByteAddress[0];
      3'b010:  req_fault = |ByteAddress[1:0];
      3'b100:  req_fault = IsStore;
      3'b101:  req_fault = IsStore | ByteAddress[0];
      default: req_fault = 1'b1;
    endcase
    if (word_idx >= 32'(MEM_DEPTH)) req_fault = 1'b1;
  end

  assign byte_sel = MemReadData[{req_q.lane, 3'b000} +: 8];
  assign half_sel = MemReadData[{req_q.lane[1], 4'b0000} +: 16];

  always_comb begin
    ext_data = MemReadData;
    case (req_q.funct3)
      3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext_data = {24'h0, byte_sel};
      3'b101:  ext_data = {16'h0, half_sel};
      default: ext_data = MemReadData;
    endcase
  end

  // Only the addressed lane is replaced; every other bit comes straight from memory.
  always_comb begin
    merged = MemReadData;
    if (req_q.funct3[0]) merged[{req_q.lane[1], 4'b0000} +: 16] = req_q.wdata[15:0];
    else                 merged[{req_q.lane, 3'b000} +: 8]      = req_q.wdata[7:0];
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    fault_d     = 1'b0;
    load_data_d = load_data_q;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          req_d.is_store = IsStore;
          req_d.funct3   = Funct3;
          req_d.lane     = ByteAddress[1:0];
          req_d.addr     = word_idx;
          req_d.wdata    = StoreData;
          if (req_fault) begin
            state_d     = S_DONE;
            fault_d     = 1'b1;
            load_data_d = 32'h0;
          end else if (IsStore && Funct3 == 3'b010) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ:    state_d = req_q.is_store ? S_MERGE : S_CAPTURE;
      S_CAPTURE: begin
        load_data_d = ext_data;
        state_d     = S_DONE;
      end
      S_MERGE: begin
        req_d.wdata = merged;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        load_data_d = 32'h0;
        state_d     = S_DONE;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
    end
  end

  assign Ready          = (state_q == S_IDLE);
  assign Done           = done_q;
  assign Fault          = fault_q;
  assign LoadData       = load_data_q;
  assign MemAddress     = req_q.addr;
  // Combinational gate so a reset arriving in WRITE suppresses the write immediately.
  assign MemWriteEnable = (state_q == S_WRITE) && !RESET;
  assign MemWriteData   = (state_q == S_WRITE) ? req_q.wdata : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 64-word registered-read memory.
module tb_load_store_unit;
  logic        CLK = 1'b0;
  logic        RESET, Req, IsStore;
  logic [2:0]  Funct3;
  logic [31:0] ByteAddress, StoreData;
  logic        Ready, Done, Fault, MemWriteEnable;
  logic [31:0] LoadData, MemAddress, MemWriteData, MemReadData;

  logic [31:0] mem [0:63];
  int          wr_cnt = 0;
  logic [31:0] last_waddr = 0, last_wdata = 0;
  int          vectors = 0, miscompares = 0;

  load_store_unit #(.MEM_DEPTH(64)) dut (
    .CLK(CLK), .RESET(RESET), .Req(Req), .IsStore(IsStore), .Funct3(Funct3),
    .ByteAddress(ByteAddress), .StoreData(StoreData), .Ready(Ready), .Done(Done),
    .Fault(Fault), .LoadData(LoadData), .MemWriteEnable(MemWriteEnable),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemReadData(MemReadData)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    MemReadData <= mem[MemAddress[5:0]];
    if (MemWriteEnable) begin
      mem[MemAddress[5:0]] <= MemWriteData;
      wr_cnt     <= wr_cnt + 1;
      last_waddr <= MemAddress;
      last_wdata <= MemWriteData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request; tog=1 wiggles Req with a conflicting store while busy.
  task automatic op(input string tag, input logic st, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] d, input int exp_cyc,
                    input logic exp_fault, input logic [31:0] exp_ld,
                    input int exp_wr, input logic tog);
    int n, got, w0;
    logic got_fault;
    logic [31:0] got_ld;
    got = -1; got_fault = 1'bx; got_ld = 32'hx;
    @(negedge CLK);
    chk({tag, " ready"}, 32'(Ready), 32'd1);
    w0 = wr_cnt;
    Req = 1'b1; IsStore = st; Funct3 = f3; ByteAddress = a; StoreData = d;
    @(posedge CLK);
    for (n = 1; n <= 8; n++) begin
      @(negedge CLK);
      if (Done && got < 0) begin
        got = n; got_fault = Fault; got_ld = LoadData;
      end
      if (tog && got < 0) begin
        Req = n[0]; IsStore = 1'b1; Funct3 = 3'b010; ByteAddress = 32'h8; StoreData = 32'h0;
      end else begin
        Req = 1'b0;
      end
      if (got >= 0) break;
    end
    chk({tag, " done_cycle"}, 32'(got), 32'(exp_cyc));
    chk({tag, " fault"}, 32'(got_fault), 32'(exp_fault));
    if (!st || exp_fault) chk({tag, " load_data"}, got_ld, exp_ld);
    chk({tag, " writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
  endtask

  initial begin
    int dpos [3];
    int nd;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    RESET = 1'b1; Req = 1'b0; IsStore = 1'b0; Funct3 = 3'b000;
    ByteAddress = 32'h0; StoreData = 32'h0;
    repeat (3) @(negedge CLK);
    chk("rst ready", 32'(Ready), 32'd1);
    chk("rst done", 32'(Done), 32'd0);
    chk("rst fault", 32'(Fault), 32'd0);
    chk("rst load_data", LoadData, 32'h0);
    chk("rst we", 32'(MemWriteEnable), 32'd0);
    chk("rst addr", MemAddress, 32'h0);
    chk("rst wdata", MemWriteData, 32'h0);
    RESET = 1'b0;

    op("sw 8", 1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1, 1'b0);
    chk("sw waddr", last_waddr, 32'd2);
    chk("sw wdata", last_wdata, 32'hDEADBEEF);
    chk("sw mem2", mem[2], 32'hDEADBEEF);
    chk("idle wdata", MemWriteData, 32'h0);

    op("lb 9",  1'b0, 3'b000, 32'h9, 32'h0, 3, 1'b0, 32'hFFFFFFBE, 0, 1'b0);
    op("lbu 9", 1'b0, 3'b100, 32'h9, 32'h0, 3, 1'b0, 32'h000000BE, 0, 1'b0);
    op("lh a",  1'b0, 3'b001, 32'hA, 32'h0, 3, 1'b0, 32'hFFFFDEAD, 0, 1'b0);
    op("lhu a", 1'b0, 3'b101, 32'hA, 32'h0, 3, 1'b0, 32'h0000DEAD, 0, 1'b0);
    op("lw 8",  1'b0, 3'b010, 32'h8, 32'h0, 3, 1'b0, 32'hDEADBEEF, 0, 1'b0);

    op("sb b", 1'b1, 3'b000, 32'hB, 32'h12345677, 4, 1'b0, 32'h0, 1, 1'b0);
    chk("sb mem2", mem[2], 32'h77ADBEEF);
    op("sh 8", 1'b1, 3'b001, 32'h8, 32'hAAAA5555, 4, 1'b0, 32'h0, 1, 1'b0);
    chk("sh mem2", mem[2], 32'h77AD5555);
    op("lb b",  1'b0, 3'b000, 32'hB, 32'h0, 3, 1'b0, 32'h00000077, 0, 1'b0);
    op("lh a2", 1'b0, 3'b001, 32'hA, 32'h0, 3, 1'b0, 32'h000077AD, 0, 1'b0);

    op("lw 6 misalign",  1'b0, 3'b010, 32'h6,   32'h0,      1, 1'b1, 32'h0, 0, 1'b0);
    op("sh 1 misalign",  1'b1, 3'b001, 32'h1,   32'hFFFF,   1, 1'b1, 32'h0, 0, 1'b0);
    op("sw 100 range",   1'b1, 3'b010, 32'h100, 32'h1,      1, 1'b1, 32'h0, 0, 1'b0);
    op("load f3 011",    1'b0, 3'b011, 32'h8,   32'h0,      1, 1'b1, 32'h0, 0, 1'b0);
    op("store f3 100",   1'b1, 3'b100, 32'h8,   32'h0,      1, 1'b1, 32'h0, 0, 1'b0);
    chk("fault mem2", mem[2], 32'h77AD5555);
    chk("fault mem0", mem[0], 32'h0);

    op("lw busy toggle", 1'b0, 3'b010, 32'h8, 32'h0, 3, 1'b0, 32'h77AD5555, 0, 1'b1);
    chk("toggle mem2", mem[2], 32'h77AD5555);

    // Req held high: loads of 3 cycles each, one idle cycle between completions.
    @(negedge CLK);
    Req = 1'b1; IsStore = 1'b0; Funct3 = 3'b010; ByteAddress = 32'h8;
    nd = 0;
    @(posedge CLK);
    for (int n = 1; n <= 11; n++) begin
      @(negedge CLK);
      if (Done) begin
        if (nd < 3) dpos[nd] = n;
        nd++;
      end
    end
    Req = 1'b0;
    chk("b2b count", 32'(nd), 32'd3);
    if (nd == 3) begin
      chk("b2b first", 32'(dpos[0]), 32'd3);
      chk("b2b second", 32'(dpos[1]), 32'd7);
      chk("b2b third", 32'(dpos[2]), 32'd11);
    end
    @(negedge CLK);
    chk("b2b idle", 32'(Ready), 32'd1);

    // Reset during MERGE of sb 0x8.
    begin
      int w0, dseen;
      w0 = wr_cnt; dseen = 0;
      Req = 1'b1; IsStore = 1'b1; Funct3 = 3'b000; ByteAddress = 32'h8; StoreData = 32'hFF;
      @(posedge CLK);
      @(negedge CLK);
      Req = 1'b0;
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      chk("rst_mid ready", 32'(Ready), 32'd1);
      chk("rst_mid we", 32'(MemWriteEnable), 32'd0);
      RESET = 1'b0;
      for (int n = 0; n < 4; n++) begin
        if (Done) dseen++;
        @(negedge CLK);
      end
      chk("rst_mid no done", 32'(dseen), 32'd0);
      chk("rst_mid no write", 32'(wr_cnt - w0), 32'd0);
      chk("rst_mid mem2", mem[2], 32'h77AD5555);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
